uart_rx: RTL and testbench
==========================

# uart_rx

Asynchronous serial receiver that pairs with the team's UART transmitter: it recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, idle high) from a single input line. It uses oversampling to find the middle of each bit. Each received byte is presented on a parallel output with a one-cycle strobe. The block sits between the board RX pin and the byte-consuming logic, in the same clock domain as the transmitter.

## Interface
- CLK_FRQ, 50000000, system clock frequency in Hz
- BAUD_RATE, 115200, line bit rate in bits/s
- OVERSAMPLE, 16, sample ticks per bit period; must be even and at least 4
- clk  input  1  system clock; all logic is on the rising edge
- areset  input  1  reset, asynchronous and active-high
- data_in  input  1  serial line, asynchronous to clk, idles high
- data_out  output  8  last correctly framed byte
- rx_done  output  1  one-cycle strobe: data_out has just been updated
- rx_busy  output  1  high while a frame is in progress or the block is recovering
- frame_err  output  1  one-cycle strobe: stop bit was sampled low

## Operation
- **Synchronizer.** data_in passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized line, called rxs.
- **Tick generator.**
  - OS_DIV = CLK_FRQ / (BAUD_RATE * OVERSAMPLE), integer division; OS_DIV must be at least 1.
  - A 32-bit counter runs freely from reset and wraps to 0 at OS_DIV-1.
  - tick is high for the one cycle in which the counter wraps.
- **Counters.** The sample counter is $clog2(OVERSAMPLE) bits wide and advances only on tick. The bit counter is 3 bits wide.
- **FSM states.** IDLE, START, DATA, STOP, RECOVER. All state changes occur only on tick cycles.
- IDLE: on a tick with rxs=0, go to START and set sample_cnt=0.
- START:
  - On each tick, increment sample_cnt.
  - On the tick where sample_cnt == OVERSAMPLE/2-1 (mid start bit): if rxs=0, go to DATA with sample_cnt=0 and bit_cnt=0.
  - Otherwise (glitch), go to IDLE with no strobe.
- DATA:
  - On the tick where sample_cnt == OVERSAMPLE-1, sample rxs into the shift register (right shift, new bit into bit 7) and reset sample_cnt.
  - After bit_cnt reaches 7 and the 8th bit is sampled, go to STOP.
- STOP, on the tick where sample_cnt == OVERSAMPLE-1:
  - If rxs=1: load data_out from the shift register, pulse rx_done, go to IDLE.
  - If rxs=0: pulse frame_err, leave data_out unchanged, go to RECOVER.
- RECOVER: stay until a tick with rxs=1, then go to IDLE. A held-low (break) line therefore does not produce repeated frames.
- **Busy.** rx_busy = (state != IDLE), decoded from the registered state.
- **Simultaneous events.** rx_done and frame_err are never high together.
- **Reset values.** Every output and internal register is reset: data_out=8'h00, rx_done=0, rx_busy=0, frame_err=0, state=IDLE, all counters 0, synchronizer 1.
- **Reset mid-frame.** The partial frame is discarded with no strobe. Reception restarts at the next falling edge seen in IDLE.

## Timing
- Input synchronizer latency: 2 clk.
- Start-edge detection uncertainty: up to 1 tick, i.e. OS_DIV clk.
- Sample points, relative to the tick that detected the start:
  - start bit: OVERSAMPLE/2 ticks later;
  - data bit n (n=0..7): OVERSAMPLE/2 + (n+1)*OVERSAMPLE ticks later;
  - stop bit: OVERSAMPLE/2 + 9*OVERSAMPLE ticks later.
- rx_done and frame_err are registered:
  - they are high for exactly the one clk cycle after the stop-sample tick edge;
  - data_out is valid in that same cycle and holds until the next good frame.
- The block returns to IDLE at mid stop bit, so back-to-back frames with a single stop bit are received without loss.
- Baud error tolerance: cumulative sample drift over 9.5 bit periods must stay under ±OVERSAMPLE/2 ticks.

## Test plan
Bench parameters: CLK_FRQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16. This gives OS_DIV=1, so tick fires every cycle and one bit is 16 clk.

1. **Reset values.** Assert areset asynchronously, mid-cycle, for 3 clk with data_in=1. Required: data_out=8'h00, rx_done=0, rx_busy=0, frame_err=0 immediately, and they hold after release.
2. **Single frame.** Send 0xA5 (line sequence 0,1,0,1,0,0,1,0,1,1). Required: data_out=8'hA5, rx_done high for exactly 1 clk, frame_err=0, rx_busy low after the strobe.
3. **Back-to-back frames.** Send 0x00 then 0xFF with one stop bit each, no idle gap. Required: two rx_done strobes about 160 clk apart, data_out=8'h00 then 8'hFF.
4. **Start-bit glitch.** Drive data_in low for 4 clk, then high. Required: rx_busy pulses for at most 10 clk, then the block returns to IDLE; no rx_done, no frame_err.
5. **Framing error.** After a good 0x11 frame, send 0x3C with the stop bit driven 0 and hold the line low for 40 clk. Required:
   - frame_err strobes once, with no rx_done;
   - data_out stays 8'h11;
   - rx_busy stays high until the line returns high;
   - a following 0x5A frame is received correctly.
6. **Reset mid-frame.** Assert areset during data bit 4 of 0xC3, then send 0x5A. Required: no strobe for 0xC3, outputs are at their reset values, and data_out=8'h5A with one rx_done.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: oversamples the synchronized line to find each bit centre
// and presents every correctly framed byte on data_out with a one-cycle strobe.
module uart_rx #(
    parameter int CLK_FRQ    = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       areset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int OS_DIV = CLK_FRQ / (BAUD_RATE * OVERSAMPLE);
    localparam int SW     = $clog2(OVERSAMPLE);

    localparam logic [31:0]   DIV_LAST = 32'(OS_DIV - 1);
    localparam logic [SW-1:0] MID_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    logic [1:0]    sync_q;
    logic [31:0]   div_q;
    logic          tick;
    logic          rxs;
    state_t        state_q;
    logic [SW-1:0] sample_cnt_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    data_q;
    logic          rx_done_q;
    logic          frame_err_q;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], data_in};
        end
    end

    assign rxs = sync_q[1];

    // Free-running oversample divider; tick marks the wrap cycle.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            div_q <= 32'd0;
        end else if (tick) begin
            div_q <= 32'd0;
        end else begin
            div_q <= div_q + 32'd1;
        end
    end

    assign tick = (div_q == DIV_LAST);

    // Receive FSM; strobes default low so each lasts a single clk.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!rxs) begin
                            state_q      <= ST_START;
                            sample_cnt_q <= '0;
                        end
                    end
                    ST_START: begin
                        if (sample_cnt_q == MID_LAST) begin
                            sample_cnt_q <= '0;
                            bit_cnt_q    <= 3'd0;
                            // A line that is high again at mid start bit was only a glitch.
                            state_q      <= rxs ? ST_IDLE : ST_DATA;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (sample_cnt_q == BIT_LAST) begin
                            sample_cnt_q <= '0;
                            shift_q      <= {rxs, shift_q[7:1]};
                            bit_cnt_q    <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= ST_STOP;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (sample_cnt_q == BIT_LAST) begin
                            sample_cnt_q <= '0;
                            if (rxs) begin
                                data_q    <= shift_q;
                                rx_done_q <= 1'b1;
                                state_q   <= ST_IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= ST_RECOVER;
                            end
                        end else begin
                            sample_cnt_q <= sample_cnt_q + 1'b1;
                        end
                    end
                    ST_RECOVER: begin
                        if (rxs) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q      <= ST_IDLE;
                        sample_cnt_q <= '0;
                        bit_cnt_q    <= 3'd0;
                    end
                endcase
            end
        end
    end

    assign data_out  = data_q;
    assign rx_done   = rx_done_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx; a byte-level scoreboard holds every
// good frame sent and is compared against the strobed outputs.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       areset = 1'b0;
    logic       data_in = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(
        .CLK_FRQ   (1600000),
        .BAUD_RATE (100000),
        .OVERSAMPLE(16)
    ) dut (
        .clk      (clk),
        .areset   (areset),
        .data_in  (data_in),
        .data_out (data_out),
        .rx_done  (rx_done),
        .rx_busy  (rx_busy),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    localparam int BIT_CLK = 16;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int dbl_cnt  = 0;
    logic       prev_done = 1'b0;
    logic [7:0] done_q[$];
    logic [7:0] exp_q[$];
    int         done_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            done_cnt++;
            done_q.push_back(data_out);
            done_t.push_back(cyc);
            if (prev_done) dbl_cnt++;
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (rx_done === 1'b1 && frame_err === 1'b1) both_cnt++;
        prev_done = (rx_done === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int n);
        data_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) drive(fr[i], BIT_CLK);
        if (stop_bit) exp_q.push_back(b);
    endtask

    initial begin
        int d0;
        int f0;
        int n0;
        int busy_n;
        logic [7:0] rb;
        logic [7:0] c3;

        // 1. asynchronous reset, mid-cycle
        #3 areset = 1'b1;
        #1;
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_rx_done", 32'(rx_done), 32'h0);
        check("rst_rx_busy", 32'(rx_busy), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        areset = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_data_out", 32'(data_out), 32'h00);
        check("post_rst_rx_done", 32'(rx_done), 32'h0);
        check("post_rst_rx_busy", 32'(rx_busy), 32'h0);
        check("post_rst_frame_err", 32'(frame_err), 32'h0);

        // 2. single frame
        d0 = done_cnt;
        send_frame(8'hA5, 1'b1);
        check("a5_busy_after", 32'(rx_busy), 32'h0);
        drive(1'b1, 20);
        check("a5_done_count", 32'(done_cnt - d0), 32'd1);
        check("a5_data_out", 32'(data_out), 32'hA5);
        check("a5_no_frame_err", 32'(fe_cnt), 32'd0);

        // 3. back-to-back frames
        d0 = done_cnt;
        n0 = done_q.size();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drive(1'b1, 20);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_first", 32'(done_q[n0]), 32'h00);
        check("b2b_second", 32'(done_q[n0 + 1]), 32'hFF);
        check("b2b_spacing", 32'(done_t[n0 + 1] - done_t[n0]), 32'd160);

        // 4. start-bit glitch
        d0 = done_cnt;
        busy_n = 0;
        data_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 4) data_in = 1'b1;
            @(negedge clk);
            if (rx_busy === 1'b1) busy_n++;
        end
        check("glitch_busy_bounded", 32'(busy_n >= 1 && busy_n <= 10), 32'd1);
        check("glitch_idle", 32'(rx_busy), 32'h0);
        check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
        check("glitch_no_ferr", 32'(fe_cnt), 32'd0);

        // 5. framing error and break recovery
        d0 = done_cnt;
        f0 = fe_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h3C, 1'b0);
        drive(1'b0, 40);
        check("ferr_busy_in_break", 32'(rx_busy), 32'h1);
        check("ferr_count", 32'(fe_cnt - f0), 32'd1);
        check("ferr_no_extra_done", 32'(done_cnt - d0), 32'd1);
        check("ferr_data_held", 32'(data_out), 32'h11);
        drive(1'b1, 20);
        check("ferr_recovered", 32'(rx_busy), 32'h0);
        send_frame(8'h5A, 1'b1);
        drive(1'b1, 20);
        check("ferr_next_frame", 32'(data_out), 32'h5A);
        check("ferr_done_total", 32'(done_cnt - d0), 32'd2);

        // 6. reset during data bit 4 of 0xC3
        d0 = done_cnt;
        f0 = fe_cnt;
        c3 = 8'hC3;
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive(c3[i], BIT_CLK);
        drive(c3[4], 8);
        #2 areset = 1'b1;
        #1;
        check("midrst_data_out", 32'(data_out), 32'h00);
        check("midrst_rx_busy", 32'(rx_busy), 32'h0);
        check("midrst_rx_done", 32'(rx_done), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        data_in = 1'b1;
        repeat (3) @(negedge clk);
        areset = 1'b0;
        drive(1'b1, 20);
        check("midrst_no_strobe", 32'(done_cnt - d0 + fe_cnt - f0), 32'd0);
        send_frame(8'h5A, 1'b1);
        drive(1'b1, 20);
        check("midrst_next_data", 32'(data_out), 32'h5A);
        check("midrst_next_done", 32'(done_cnt - d0), 32'd1);

        // 7. random bytes with random idle gaps
        for (int k = 0; k < 8; k++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1);
            drive(1'b1, $urandom_range(0, 24));
        end
        drive(1'b1, 20);

        // scoreboard and global properties
        check("sb_count", 32'(done_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("sb_byte_%0d", i), 32'(done_q[i]), 32'(exp_q[i]));
        end
        check("total_frame_err", 32'(fe_cnt), 32'd1);
        check("done_single_cycle", 32'(dbl_cnt), 32'd0);
        check("done_ferr_exclusive", 32'(both_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
